// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared state encoding, width default and Hi/Lo write-select codes.
package mult_div_unit_pkg;
  localparam int WIDTH_DEF = 32;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    DFIX = 3'd3,
    DONE = 3'd4
  } state_e;
  localparam logic [1:0] WSEL_NONE = 2'b00;
  localparam logic [1:0] WSEL_LO   = 2'b01;
  localparam logic [1:0] WSEL_HI   = 2'b10;
  localparam logic [1:0] WSEL_BOTH = 2'b11;
endpackage

// File: rtl/mult_div_unit_booth_step.sv
// mult_div_unit_booth_step: one radix-2 Booth iteration on {acc, mq, q1}.
module mult_div_unit_booth_step
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mq,
  input  logic             q1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_n,
  output logic [WIDTH-1:0] mq_n,
  output logic             q1_n
);
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;
  // acc carries one guard bit so subtracting -2^(W-1) cannot overflow
  assign m_ext = {m[WIDTH-1], m};
  always_comb begin
    sum   = (mq[0] & ~q1) ? acc - m_ext : (~mq[0] & q1) ? acc + m_ext : acc;
    acc_n = {sum[WIDTH], sum[WIDTH:1]};
    mq_n  = {sum[0], mq[WIDTH-1:1]};
    q1_n  = mq[0];
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed Booth multiplier and restoring divider writing Hi/Lo.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             MultStart,
  input  logic             DivStart,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Done,
  output logic             Busy,
  output logic             DivZero
);
  localparam int CW = $clog2(ITER);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic             q1_q, q1_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic             done_q, done_d, divz_q, divz_d;
  logic [WIDTH:0]   b_acc, t, diff;
  logic [WIDTH-1:0] b_mq, a_mag, b_mag;
  logic [1:0]       wsel;
  logic             b_q1, last, start, ge;

  mult_div_unit_booth_step #(.WIDTH(WIDTH)) u_booth (
    .acc(acc_q), .mq(mq_q), .q1(q1_q), .m(m_q),
    .acc_n(b_acc), .mq_n(b_mq), .q1_n(b_q1)
  );

  assign a_mag = A[WIDTH-1] ? -A : A;
  assign b_mag = B[WIDTH-1] ? -B : B;
  assign last  = cnt_q == CW'(ITER - 1);
  assign start = state_q == IDLE && (MultStart || DivStart);
  // restoring step: shift next dividend bit into the partial remainder
  assign t     = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
  assign ge    = t >= {1'b0, m_q};
  assign diff  = t - {1'b0, m_q};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      m_q     <= '0;
      q1_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      m_q     <= m_d;
      q1_q    <= q1_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = MultStart ? MULT : DivStart ? (B == '0 ? DONE : DIV) : IDLE;
      MULT:    state_d = last ? DONE : MULT;
      DIV:     state_d = last ? DFIX : DIV;
      DFIX:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    mq_d   = mq_q;
    m_d    = m_q;
    q1_d   = q1_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    cnt_d  = (state_q == MULT || state_q == DIV) ? (last ? '0 : cnt_q + 1'b1) : '0;
    unique case (state_q)
      IDLE: begin
        if (MultStart) begin
          acc_d = '0;
          mq_d  = B;
          m_d   = A;
          q1_d  = 1'b0;
          dz_d  = 1'b0;
        end else if (DivStart) begin
          acc_d  = '0;
          mq_d   = a_mag;
          m_d    = b_mag;
          qneg_d = A[WIDTH-1] ^ B[WIDTH-1];
          rneg_d = A[WIDTH-1];
          dz_d   = B == '0;
        end
      end
      MULT: begin
        acc_d = b_acc;
        mq_d  = b_mq;
        q1_d  = b_q1;
      end
      DIV: begin
        acc_d = ge ? diff : t;
        mq_d  = {mq_q[WIDTH-2:0], ge};
      end
      DFIX: begin
        mq_d  = qneg_q ? -mq_q : mq_q;
        acc_d = {1'b0, rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    wsel   = (state_q == DONE && !dz_q) ? WSEL_BOTH : WSEL_NONE;
    hi_d   = wsel[1] ? acc_q[WIDTH-1:0] : hi_q;
    lo_d   = wsel[0] ? mq_q : lo_q;
    done_d = state_q == DONE;
    divz_d = state_q == DONE ? dz_q : start ? 1'b0 : divz_q;
  end

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Done    = done_q;
  assign DivZero = divz_q;
  assign Busy    = state_q != IDLE || done_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed multiply/divide vectors with hand-computed Hi/Lo and latency.
module tb_mult_div_unit;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        MultStart = 1'b0;
  logic        DivStart = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] Hi, Lo;
  logic        Done, Busy, DivZero;
  int          checks = 0;
  int          errors = 0;

  mult_div_unit dut (
    .Clock(Clock), .Reset(Reset), .MultStart(MultStart), .DivStart(DivStart),
    .A(A), .B(B), .Hi(Hi), .Lo(Lo), .Done(Done), .Busy(Busy), .DivZero(DivZero)
  );

  always #5 Clock = ~Clock;

  // start edge is edge 0; lat is the edge after which Done is seen (0 = timeout)
  task automatic run_op(input logic mul, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_at, output int lat);
    @(negedge Clock);
    MultStart = mul;
    DivStart  = !mul;
    A = a;
    B = b;
    @(posedge Clock);
    #1;
    MultStart = 1'b0;
    DivStart  = 1'b0;
    A = 32'hDEAD_BEEF;
    B = 32'h0BAD_F00D;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == pulse_at) begin
        @(negedge Clock);
        DivStart = 1'b1;
        B = '0;
      end
      @(posedge Clock);
      #1;
      DivStart = 1'b0;
      if (Done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({Hi, Lo, Done, Busy, DivZero} !== 67'd0) begin
      errors++;
      $display("FAIL reset: got Hi=%h Lo=%h Done=%b Busy=%b DivZero=%b, want all 0", Hi, Lo, Done, Busy, DivZero);
    end
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_mult;
    int lat;
    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 0, lat);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
    checks++;
    if ({Hi, Lo, DivZero} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}) begin
      errors++;
      $display("FAIL mult_7x-3: got Hi=%h Lo=%h DivZero=%b want FFFFFFFF FFFFFFEB 0", Hi, Lo, DivZero);
    end
    @(posedge Clock);
    #1;
    checks++;
    if ({Done, Busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_pulse: got Done=%b Busy=%b want 0 0", Done, Busy);
    end
  endtask

  task automatic test_mult_corner;
    int lat;
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0, lat);
    checks++;
    if ({Hi, Lo} !== {32'h4000_0000, 32'h0} || lat !== 33) begin
      errors++;
      $display("FAIL mult_min_sq: got Hi=%h Lo=%h lat=%0d want 40000000 00000000 33", Hi, Lo, lat);
    end
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat);
    checks++;
    if ({Hi, Lo} !== {32'h0, 32'h1}) begin
      errors++;
      $display("FAIL mult_m1_sq: got Hi=%h Lo=%h want 00000000 00000001", Hi, Lo);
    end
  endtask

  task automatic test_div;
    int lat;
    run_op(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 0, lat);
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL div_latency: got %0d want 34", lat); end
    checks++;
    if ({Hi, Lo, DivZero} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}) begin
      errors++;
      $display("FAIL div_-7/2: got Hi=%h Lo=%h DivZero=%b want FFFFFFFF FFFFFFFD 0", Hi, Lo, DivZero);
    end
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat);
    checks++;
    if ({Hi, Lo} !== {32'h0, 32'h8000_0000}) begin
      errors++;
      $display("FAIL div_overflow: got Hi=%h Lo=%h want 00000000 80000000", Hi, Lo);
    end
    run_op(1'b0, 32'd100, 32'd7, 0, lat);
    checks++;
    if ({Hi, Lo} !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL div_100/7: got Hi=%h Lo=%h want 00000002 0000000e", Hi, Lo);
    end
    run_op(1'b0, 32'd7, 32'hFFFF_FFFE, 0, lat);
    checks++;
    if ({Hi, Lo} !== {32'd1, 32'hFFFF_FFFD}) begin
      errors++;
      $display("FAIL div_7/-2: got Hi=%h Lo=%h want 00000001 FFFFFFFD", Hi, Lo);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    run_op(1'b1, 32'h1234_5678, 32'h0001_0000, 0, lat);
    checks++;
    if ({Hi, Lo} !== {32'h0000_1234, 32'h5678_0000}) begin
      errors++;
      $display("FAIL dz_setup: got Hi=%h Lo=%h want 00001234 56780000", Hi, Lo);
    end
    run_op(1'b0, 32'd55, 32'd0, 0, lat);
    checks++;
    if (lat !== 1 || DivZero !== 1'b1) begin
      errors++;
      $display("FAIL dz_flag: got lat=%0d DivZero=%b want 1 1", lat, DivZero);
    end
    checks++;
    if ({Hi, Lo} !== {32'h0000_1234, 32'h5678_0000}) begin
      errors++;
      $display("FAIL dz_hold: got Hi=%h Lo=%h want 00001234 56780000", Hi, Lo);
    end
    @(posedge Clock);
    #1;
    checks++;
    if ({Done, DivZero} !== 2'b01) begin
      errors++;
      $display("FAIL dz_sticky: got Done=%b DivZero=%b want 0 1", Done, DivZero);
    end
    run_op(1'b1, 32'd2, 32'd3, 0, lat);
    checks++;
    if ({Hi, Lo, DivZero} !== {32'd0, 32'd6, 1'b0}) begin
      errors++;
      $display("FAIL dz_clear: got Hi=%h Lo=%h DivZero=%b want 0 6 0", Hi, Lo, DivZero);
    end
  endtask

  task automatic test_ignored_start;
    int lat;
    run_op(1'b1, 32'd100, 32'd3, 10, lat);
    checks++;
    if ({Hi, Lo, DivZero} !== {32'd0, 32'd300, 1'b0} || lat !== 33) begin
      errors++;
      $display("FAIL ignored_start: got Hi=%h Lo=%h DivZero=%b lat=%0d want 0 12c 0 33", Hi, Lo, DivZero, lat);
    end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    @(negedge Clock);
    MultStart = 1'b1;
    A = 32'd9;
    B = 32'd9;
    @(posedge Clock);
    #1;
    MultStart = 1'b0;
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL busy: got %b want 1", Busy); end
    repeat (20) @(posedge Clock);
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if ({Hi, Lo, Done, Busy, DivZero} !== 67'd0) begin
      errors++;
      $display("FAIL reset_mid: got Hi=%h Lo=%h Done=%b Busy=%b DivZero=%b want all 0", Hi, Lo, Done, Busy, DivZero);
    end
    @(negedge Clock);
    Reset = 1'b1;
    repeat (40) begin
      @(posedge Clock);
      #1;
      if (Done) seen++;
    end
    checks++;
    if (seen !== 0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got %0d Done pulses Busy=%b want 0 0", seen, Busy);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_mult_corner;
    test_div;
    test_div_zero;
    test_ignored_start;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
